// File: rtl/quad_encoder_decoder_if.sv
// Encoder-side signal bundle: raw A/B channels in, step strobe/direction/error out.
interface quad_encoder_decoder_if;
  logic enc_a;
  logic enc_b;
  logic en;
  logic down;
  logic err;

  modport master (output enc_a, output enc_b, input en, input down, input err);
  modport slave  (input enc_a, input enc_b, output en, output down, output err);
endinterface

// File: rtl/quad_encoder_decoder.sv
// Rotary encoder front end: two-FF synchronisers, per-channel debounce, Gray-code
// step decoding into single-cycle en strobes with a held down flag and err pulses.
module quad_encoder_decoder #(
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter bit          DETENT_MODE = 1'b1
) (
  input logic                   clk50m,
  input logic                   rst_n,
  quad_encoder_decoder_if.slave enc_if
);

  localparam int unsigned   CW        = $clog2(DEB_CYCLES);
  localparam int unsigned   IW        = $clog2(DEB_CYCLES + 2);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  // Start-up settle covers the synchroniser latency as well as a full debounce period.
  localparam logic [IW-1:0] INIT_LAST = IW'(DEB_CYCLES + 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    deb_q;
  logic [1:0]    deb_d;
  logic [CW-1:0] cnt_a_q;
  logic [CW-1:0] cnt_a_d;
  logic [CW-1:0] cnt_b_q;
  logic [CW-1:0] cnt_b_d;
  state_e        state_q;
  state_e        state_d;
  logic [1:0]    prev_q;
  logic [1:0]    prev_d;
  logic [IW-1:0] init_q;
  logic [IW-1:0] init_d;
  logic          en_q;
  logic          en_d;
  logic          down_q;
  logic          down_d;
  logic          err_q;
  logic          err_d;
  logic          fwd;
  logic          rev;
  logic          stable;

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  // Returns {next debounced bit, next counter}.
  function automatic logic [CW:0] deb_step(input logic s, input logic d, input logic [CW-1:0] c);
    logic          d_n;
    logic [CW-1:0] c_n;
    d_n = d;
    c_n = '0;
    if (s != d) begin
      if (c == DEB_LAST) d_n = s;
      else               c_n = c + 1'b1;
    end
    return {d_n, c_n};
  endfunction

  always_comb begin
    {deb_d[1], cnt_a_d} = deb_step(sync2_q[1], deb_q[1], cnt_a_q);
    {deb_d[0], cnt_b_d} = deb_step(sync2_q[0], deb_q[0], cnt_b_q);
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      sync1_q <= {enc_if.enc_a, enc_if.enc_b};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign fwd    = (fwd_next(prev_q) == deb_q);
  assign rev    = (fwd_next(deb_q) == prev_q);
  assign stable = (sync2_q == deb_q) && (deb_q == prev_q);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    init_d  = init_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    down_d  = down_q;
    case (state_q)
      S_INIT: begin
        prev_d = deb_q;
        if (!stable) begin
          init_d = '0;
        end else if (init_q == INIT_LAST) begin
          init_d  = '0;
          state_d = S_RUN;
        end else begin
          init_d = init_q + 1'b1;
        end
      end
      S_RUN: begin
        if (deb_q != prev_q) begin
          prev_d = deb_q;
          if (fwd) begin
            if (!DETENT_MODE || (deb_q == 2'b11 && prev_q == 2'b01)) begin
              en_d   = 1'b1;
              down_d = 1'b0;
            end
          end else if (rev) begin
            if (!DETENT_MODE || (deb_q == 2'b11 && prev_q == 2'b10)) begin
              en_d   = 1'b1;
              down_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      prev_q  <= '1;
      init_q  <= '0;
      en_q    <= 1'b0;
      down_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      init_q  <= init_d;
      en_q    <= en_d;
      down_q  <= down_d;
      err_q   <= err_d;
    end
  end

  assign enc_if.en   = en_q;
  assign enc_if.down = down_q;
  assign enc_if.err  = err_q;

endmodule
